// File: rtl/bimodal_branch_predictor.sv
// bimodal_branch_predictor: 2-bit saturating-counter branch history table with mispredict statistics
module bimodal_branch_predictor #(
  parameter int         INDEX_BITS   = 6,
  parameter logic [1:0] COUNTER_INIT = 2'b01,
  parameter int         STAT_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           FetchPC_i,
  output logic                  PredTaken_o,
  input  logic                  UpdateEn_i,
  input  logic [31:0]           UpdatePC_i,
  input  logic                  ActualTaken_i,
  input  logic                  PredTakenEX_i,
  output logic                  Mispredict_o,
  output logic [STAT_WIDTH-1:0] BranchCount_o,
  output logic [STAT_WIDTH-1:0] MispredCount_o
);
  localparam int DEPTH = 2 ** INDEX_BITS;
  logic [1:0] tbl [DEPTH];
  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [1:0] cur, nxt;
  logic unused;
  assign f_idx = FetchPC_i[INDEX_BITS+1:2];
  assign u_idx = UpdatePC_i[INDEX_BITS+1:2];
  assign unused = ^{FetchPC_i[31:INDEX_BITS+2], FetchPC_i[1:0], UpdatePC_i[31:INDEX_BITS+2], UpdatePC_i[1:0]};
  assign PredTaken_o = tbl[f_idx][1];
  assign Mispredict_o = UpdateEn_i & (ActualTaken_i != PredTakenEX_i);
  assign cur = tbl[u_idx];
  always_comb begin
    nxt = ActualTaken_i ? ((cur == 2'b11) ? cur : cur + 2'd1)
                        : ((cur == 2'b00) ? cur : cur - 2'd1);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= COUNTER_INIT;
      BranchCount_o  <= '0;
      MispredCount_o <= '0;
    end else if (UpdateEn_i) begin
      tbl[u_idx] <= nxt;
      if (!(&BranchCount_o)) BranchCount_o <= BranchCount_o + STAT_WIDTH'(1);
      if (Mispredict_o && !(&MispredCount_o)) MispredCount_o <= MispredCount_o + STAT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// tb_bimodal_branch_predictor: table-driven check of prediction, update, aliasing, hazard, reset and stat saturation
module tb_bimodal_branch_predictor;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] FetchPC_i, UpdatePC_i;
  logic        UpdateEn_i, ActualTaken_i, PredTakenEX_i;
  logic        PredTaken_o, Mispredict_o, pred_s, mis_s;
  logic [31:0] BranchCount_o, MispredCount_o;
  logic [3:0]  bc_s, mc_s;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bimodal_branch_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i), .FetchPC_i(FetchPC_i), .PredTaken_o(PredTaken_o),
    .UpdateEn_i(UpdateEn_i), .UpdatePC_i(UpdatePC_i), .ActualTaken_i(ActualTaken_i),
    .PredTakenEX_i(PredTakenEX_i), .Mispredict_o(Mispredict_o),
    .BranchCount_o(BranchCount_o), .MispredCount_o(MispredCount_o)
  );

  bimodal_branch_predictor #(.STAT_WIDTH(4)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .FetchPC_i(FetchPC_i), .PredTaken_o(pred_s),
    .UpdateEn_i(UpdateEn_i), .UpdatePC_i(UpdatePC_i), .ActualTaken_i(ActualTaken_i),
    .PredTakenEX_i(PredTakenEX_i), .Mispredict_o(mis_s),
    .BranchCount_o(bc_s), .MispredCount_o(mc_s)
  );

  typedef struct {
    logic [31:0] fpc;
    logic        en;
    logic [31:0] upc;
    logic        act;
    logic        pex;
    logic        exp_pred;
    logic        exp_mis;
    logic [31:0] exp_bc;
    logic [31:0] exp_mc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] fpc, input logic en, input logic [31:0] upc,
                       input logic act, input logic pex);
    @(negedge clk_i);
    FetchPC_i = fpc; UpdateEn_i = en; UpdatePC_i = upc; ActualTaken_i = act; PredTakenEX_i = pex;
    #1;
  endtask

  task automatic sweep_clear(input string tag);
    for (int p = 0; p <= 32'hFC; p += 4) begin
      FetchPC_i = p;
      #0.1;
      check($sformatf("%s_pred_%0h", tag, p), {31'd0, PredTaken_o}, 32'd0);
    end
    check({tag, "_bc"}, BranchCount_o, 32'd0);
    check({tag, "_mc"}, MispredCount_o, 32'd0);
  endtask

  initial begin
    //          fetch    en  upd       act  pex  pred mis bc  mc
    vecs[0]  = '{32'h40,  1, 32'h40,   1,   0,   0,   1,  0,  0};
    vecs[1]  = '{32'h40,  1, 32'h40,   1,   0,   1,   1,  1,  1};
    vecs[2]  = '{32'h40,  1, 32'h40,   1,   0,   1,   1,  2,  2};
    vecs[3]  = '{32'h40,  1, 32'h40,   1,   0,   1,   1,  3,  3};
    vecs[4]  = '{32'h40,  1, 32'h40,   0,   1,   1,   1,  4,  4};
    vecs[5]  = '{32'h40,  1, 32'h40,   0,   1,   1,   1,  5,  5};
    vecs[6]  = '{32'h40,  0, 32'h40,   1,   0,   0,   0,  6,  6};
    vecs[7]  = '{32'h04,  1, 32'h104,  1,   0,   0,   1,  6,  6};
    vecs[8]  = '{32'h06,  1, 32'h104,  1,   0,   1,   1,  7,  7};
    vecs[9]  = '{32'h04,  0, 32'h0,    0,   0,   1,   0,  8,  8};
    vecs[10] = '{32'h06,  0, 32'h0,    0,   0,   1,   0,  8,  8};
    vecs[11] = '{32'h80,  1, 32'h80,   1,   1,   0,   0,  8,  8};
    vecs[12] = '{32'h80,  0, 32'h80,   1,   0,   1,   0,  9,  8};
    vecs[13] = '{32'h80,  1, 32'h80,   1,   0,   1,   1,  9,  8};

    rst_i = 1'b1; UpdateEn_i = 1'b0; FetchPC_i = '0; UpdatePC_i = '0;
    ActualTaken_i = 1'b0; PredTakenEX_i = 1'b0;
    #1;
    check("mis_in_reset_idle", {31'd0, Mispredict_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    sweep_clear("init");

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].fpc, vecs[i].en, vecs[i].upc, vecs[i].act, vecs[i].pex);
      check($sformatf("v%0d_pred", i), {31'd0, PredTaken_o}, {31'd0, vecs[i].exp_pred});
      check($sformatf("v%0d_mis", i), {31'd0, Mispredict_o}, {31'd0, vecs[i].exp_mis});
      check($sformatf("v%0d_bc", i), BranchCount_o, vecs[i].exp_bc);
      check($sformatf("v%0d_mc", i), MispredCount_o, vecs[i].exp_mc);
    end
    drive(32'h80, 0, 32'h0, 0, 0);
    check("after_bc", BranchCount_o, 32'd10);
    check("after_mc", MispredCount_o, 32'd9);
    check("after_bc_small", {28'd0, bc_s}, 32'd10);
    check("after_mc_small", {28'd0, mc_s}, 32'd9);

    // reset with a simultaneous mispredicted taken update: update must be dropped
    drive(32'h40, 1, 32'h40, 1, 0);
    rst_i = 1'b1;
    #0.1;
    check("mis_in_reset_upd", {31'd0, Mispredict_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0; UpdateEn_i = 1'b0;
    sweep_clear("rst");

    for (int i = 0; i < 20; i++) drive(32'h0, 1, 32'h8, 1, 0);
    drive(32'h0, 0, 32'h0, 0, 0);
    check("sat_bc_small", {28'd0, bc_s}, 32'hF);
    check("sat_mc_small", {28'd0, mc_s}, 32'hF);
    check("sat_bc_wide", BranchCount_o, 32'd20);
    check("sat_mc_wide", MispredCount_o, 32'd20);
    FetchPC_i = 32'h8;
    #0.1;
    check("sat_pred_8", {31'd0, PredTaken_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
